// File: rtl/sub16_nibble_serial.sv
// sub16_nibble_serial: 16-bit subtractor (a - b - bin), one 4-bit nibble per clock.
// Each nibble is a 4-bit borrow-lookahead group; the carry ripples between nibbles through a register.
// Latency: start sampled at E0, done pulses for one cycle after E4. Issue rate is one operation per 6 cycles.
// Backpressure: none. start is only sampled in IDLE, and a start in RUN or DONE is dropped (no queuing).
//
// Ports:
//   clk, rst_n      clock (rising edge); asynchronous active-low reset
//   start           request, accepted only in IDLE
//   a, b, bin       minuend, subtrahend, borrow-in (captured on accept)
//   busy            high while in RUN
//   done            one-cycle pulse, result valid
//   diff            a - b - bin mod 2^16, held until the next accepted op
//   bout            borrow out
//   ovf             signed overflow (only when SUB16_OVF_FLAG_EN is defined)
//
// Build option: define SUB16_OVF_FLAG_EN to add the ovf port and its logic.
module sub16_nibble_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] diff,
  output logic        bout
`ifdef SUB16_OVF_FLAG_EN
  ,
  output logic        ovf
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        carry_q, carry_d;
  logic [15:0] diff_q, diff_d;
  logic        bout_q, bout_d;

  // Nibble datapath: a + ~b + carry, where carry is the inverted borrow.
  logic [3:0] nib_x, nib_y;
  logic [3:0] nib_p, nib_g;
  logic [3:0] nib_c;
  logic [3:0] nib_sum;
  logic       grp_p, grp_g, grp_cout;

  always_comb begin
    nib_x = a_q[{idx_q, 2'b00} +: 4];
    nib_y = ~b_q[{idx_q, 2'b00} +: 4];
    nib_g = nib_x & nib_y;
    nib_p = nib_x ^ nib_y;
    // Internal bit carries, flattened so they all come straight from carry_q.
    nib_c[0] = carry_q;
    nib_c[1] = nib_g[0] | (nib_p[0] & carry_q);
    nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & carry_q);
    nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
             | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
    nib_sum  = nib_p ^ nib_c;
    grp_p    = &nib_p;
    grp_g    = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
             | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0]);
    grp_cout = grp_g | (grp_p & carry_q);
  end

`ifdef SUB16_OVF_FLAG_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SUB16_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = ~bin;
          idx_d   = 2'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d[{idx_q, 2'b00} +: 4] = nib_sum;
        carry_d = grp_cout;
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = ST_DONE;
          bout_d  = ~grp_cout;
`ifdef SUB16_OVF_FLAG_EN
          // nib_sum[3] is the new diff[15] being written this cycle.
          ovf_d   = (a_q[15] ^ b_q[15]) & (a_q[15] ^ nib_sum[3]);
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      carry_q <= 1'b0;
      diff_q  <= 16'd0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SUB16_OVF_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_sub16_nibble_serial.sv
// tb_sub16_nibble_serial: self-checking bench for sub16_nibble_serial.
// Directed and random operations are compared against an arithmetic reference model, with timing and reset checks.
// Also covers start held high continuously and a reset taken during RUN.
module tb_sub16_nibble_serial;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
`ifdef SUB16_OVF_FLAG_EN
  logic        ovf;
`endif

  int n_checks;
  int n_fail;

  sub16_nibble_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB16_OVF_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic logic [15:0] ref_diff(input logic [15:0] x, input logic [15:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return r[15:0];
  endfunction

  function automatic logic ref_bout(input logic [15:0] x, input logic [15:0] y, input logic c);
    return int'(x) < (int'(y) + int'(c));
  endfunction

  function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y, input logic c);
    int r;
    r = int'($signed(x)) - int'($signed(y)) - int'(c);
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic check_result(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c);
    chk({tag, "_diff"}, 32'(diff), 32'(ref_diff(x, y, c)));
    chk({tag, "_bout"}, 32'(bout), 32'(ref_bout(x, y, c)));
`ifdef SUB16_OVF_FLAG_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(x, y, c)));
`endif
  endtask

  // One operation from IDLE. Operands are scrambled during RUN to show they were captured.
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c);
    int cyc;
    @(negedge clk);
    a = x; b = y; bin = c; start = 1'b1;
    @(posedge clk);                      // E0
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 12) begin
      chk({tag, "_busy_run"}, 32'(busy), 32'd1);
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd4);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    check_result(tag, x, y, c);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_result({tag, "_hold"}, x, y, c);
  endtask

  logic [15:0] ops_a[0:35];
  logic [15:0] ops_b[0:35];
  logic        ops_c[0:35];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #23;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
`ifdef SUB16_OVF_FLAG_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op("d1234", 16'h1234, 16'h0034, 1'b0);
    chk("d1234_val", 32'(diff), 32'h1200);
    run_op("dprop", 16'h0000, 16'h0001, 1'b0);
    chk("dprop_val", 32'(diff), 32'hFFFF);
    run_op("d8000", 16'h8000, 16'h0001, 1'b0);
`ifdef SUB16_OVF_FLAG_EN
    chk("d8000_ovf_val", 32'(ovf), 32'd1);
`endif
    run_op("deqbin", 16'h0005, 16'h0005, 1'b1);
    chk("deqbin_bout_val", 32'(bout), 32'd1);
    run_op("dmax", 16'hFFFF, 16'hFFFF, 1'b1);
    run_op("dzero", 16'h0000, 16'h0000, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_op($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom));
    end

    // start held high with operands changing every cycle. Edge j is the j-th posedge after start rises.
    // Accepts land on edges 0, 6, 12, ... and each done is observed right after edge accept+4.
    begin
      int n_done;
      n_done = 0;
      @(negedge clk);
      start = 1'b1;
      for (int j = 0; j < 30; j++) begin
        ops_a[j] = 16'($urandom); ops_b[j] = 16'($urandom); ops_c[j] = 1'($urandom);
        a = ops_a[j]; b = ops_b[j]; bin = ops_c[j];
        @(negedge clk);
        chk($sformatf("hold_done_e%0d", j), 32'(done), 32'((j % 6) == 4));
        if (done && j >= 4) begin
          n_done++;
          check_result($sformatf("hold_e%0d", j), ops_a[j-4], ops_b[j-4], ops_c[j-4]);
        end
      end
      start = 1'b0;
      chk("hold_count", 32'(n_done), 32'd5);
    end
    repeat (6) @(negedge clk);

    // Reset taken during nibble 2.
    @(negedge clk);
    a = 16'h9ABC; b = 16'h1357; bin = 1'b0; start = 1'b1;
    @(posedge clk);                      // E0
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);                      // after E1
    @(negedge clk);                      // after E2, nibble 2 in progress
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_diff", 32'(diff), 32'd0);
    chk("mrst_bout", 32'(bout), 32'd0);
`ifdef SUB16_OVF_FLAG_EN
    chk("mrst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("mrst_nodone%0d", k), 32'(done), 32'd0);
    end
    run_op("post_rst", 16'h9ABC, 16'h1357, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
